// File: rtl/arbiter_wrr_if.sv
// Bundle of request/weight inputs and grant-side outputs shared between the
// bus masters (master modport) and the weighted round-robin arbiter (slave modport).
interface arbiter_wrr_if #(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  parameter int ID_W      = 2
);
  logic [0:NUM_PORTS-1]          request;
  logic [NUM_PORTS*WEIGHT_W-1:0] weight;
  logic [0:NUM_PORTS-1]          grant;
  logic [ID_W-1:0]               grant_id;
  logic                          active;
  logic                          expired;

  modport master (
    output request, weight,
    input  grant, grant_id, active, expired
  );

  modport slave (
    input  request, weight,
    output grant, grant_id, active, expired
  );
endinterface

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: each owner keeps a registered one-hot grant for up
// to its latched quota of cycles, handing over back-to-back with no idle bubble.
module arbiter_wrr #(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  parameter int ID_W      = 2
) (
  input  logic          clk,
  input  logic          rst,
  arbiter_wrr_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  cnt_q, cnt_d;
  logic [WEIGHT_W-1:0]  q_q, q_d;
  logic [0:NUM_PORTS-1] grant_q, grant_d;
  logic                 exp_q, exp_d;
  logic [ID_W-1:0]      win;
  logic [ID_W-1:0]      nxt;
  logic                 take;

  // First requester at or after start, wrapping; starting just past the owner
  // naturally places the owner last in the scan.
  function automatic logic [ID_W-1:0] search(input logic [0:NUM_PORTS-1] req,
                                             input logic [ID_W-1:0] start);
    logic [ID_W-1:0] w;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(start) + k) % NUM_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        w     = ID_W'(idx);
      end
    end
    return w;
  endfunction

  function automatic logic [WEIGHT_W-1:0] eff_quota(input logic [NUM_PORTS*WEIGHT_W-1:0] wv,
                                                    input logic [ID_W-1:0] p);
    logic [WEIGHT_W-1:0] v;
    v = wv[int'(p)*WEIGHT_W +: WEIGHT_W];
    return (v == '0) ? WEIGHT_W'(1) : v;
  endfunction

  function automatic logic [0:NUM_PORTS-1] onehot(input logic [ID_W-1:0] p);
    logic [0:NUM_PORTS-1] g;
    g    = '0;
    g[p] = 1'b1;
    return g;
  endfunction

  assign nxt = (owner_q == ID_W'(NUM_PORTS-1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      q_q     <= WEIGHT_W'(1);
      grant_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      grant_q <= grant_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    grant_d = grant_q;
    exp_d   = 1'b0;
    take    = 1'b0;
    win     = search(bus.request, ptr_q);
    unique case (state_q)
      IDLE: take = |bus.request;
      GRANT: begin
        // A dropped request always wins over quota expiry: no expired pulse.
        if (!bus.request[owner_q]) begin
          ptr_d = nxt;
          win   = search(bus.request, nxt);
          take  = |bus.request;
          if (!take) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (cnt_q == q_q - 1'b1) begin
          exp_d = 1'b1;
          ptr_d = nxt;
          win   = search(bus.request, nxt);
          take  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    if (take) begin
      state_d = GRANT;
      owner_d = win;
      cnt_d   = '0;
      q_d     = eff_quota(bus.weight, win);
      grant_d = onehot(win);
    end
  end

  always_comb begin
    bus.grant    = grant_q;
    bus.grant_id = owner_q;
    bus.active   = |grant_q;
    bus.expired  = exp_q;
  end

endmodule

// File: tb/tb_arbiter_wrr.sv
// Bench for arbiter_wrr (3 ports): directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a tenure-level reference model.
module tb_arbiter_wrr;
  localparam int N  = 3;
  localparam int WW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arbiter_wrr_if #(.NUM_PORTS(N), .WEIGHT_W(WW), .ID_W(IW)) bus();
  arbiter_wrr #(.NUM_PORTS(N), .WEIGHT_W(WW), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: who owns the resource, how many cycles of the tenure are used.
  typedef struct packed {
    int owner;
    int last_id;
    int ptr;
    int held;
    int quota;
    bit exp;
  } mdl_t;

  localparam mdl_t MDL_RST = '{owner: -1, last_id: 0, ptr: 0, held: 0, quota: 1, exp: 1'b0};

  function automatic int pick(input logic [0:N-1] req, input int start);
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic int quota_of(input logic [N*WW-1:0] w, input int p);
    int v;
    v = int'((w >> (p * WW)) & 12'hF);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input logic [0:N-1] req,
                                      input logic [N*WW-1:0] w);
    mdl_t n;
    int   p;
    n     = m;
    n.exp = 1'b0;
    p     = -1;
    if (m.owner < 0) begin
      p = pick(req, m.ptr);
    end else if (!req[m.owner]) begin
      n.ptr = (m.owner + 1) % N;
      p     = pick(req, n.ptr);
      if (p < 0) n.owner = -1;
    end else if (m.held >= m.quota) begin
      n.exp = 1'b1;
      n.ptr = (m.owner + 1) % N;
      p     = pick(req, n.ptr);
    end else begin
      n.held = m.held + 1;
    end
    if (p >= 0) begin
      n.owner   = p;
      n.last_id = p;
      n.held    = 1;
      n.quota   = quota_of(w, p);
    end
    return n;
  endfunction

  mdl_t m;
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= MDL_RST;
    else      m <= model_next(m, bus.request, bus.weight);
  end

  // Every cycle: DUT outputs against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("model.grant", 32'(bus.grant), (m.owner < 0) ? 32'd0 : 32'(1 << (N - 1 - m.owner)));
      chk("model.grant_id", 32'(bus.grant_id), 32'(m.last_id));
      chk("model.active", 32'(bus.active), 32'(m.owner >= 0));
      chk("model.expired", 32'(bus.expired), 32'(m.exp));
    end
  end

  task automatic cyc_chk(input string nm, input logic [0:N-1] g, input logic e,
                         input logic [IW-1:0] id);
    @(negedge clk);
    chk({nm, ".grant"}, 32'(bus.grant), 32'(g));
    chk({nm, ".expired"}, 32'(bus.expired), 32'(e));
    chk({nm, ".grant_id"}, 32'(bus.grant_id), 32'(id));
    chk({nm, ".active"}, 32'(bus.active), 32'(g != '0));
  endtask

  task automatic do_reset(input logic [N*WW-1:0] w, input logic [0:N-1] req);
    rst         = 1'b0;
    bus.request = '0;
    bus.weight  = w;
    @(negedge clk);
    @(negedge clk);
    rst         = 1'b1;
    bus.request = req;
  endtask

  initial begin
    bus.request = 3'b111;
    bus.weight  = 12'h111;
    rst         = 1'b0;

    // Reset held with all ports requesting.
    for (int i = 0; i < 10; i++) cyc_chk("reset", 3'b000, 1'b0, 2'd0);
    rst = 1'b1;
    cyc_chk("reset.release", 3'b100, 1'b0, 2'd0);

    // Sole requester with quota 2 is re-granted with an expiry pulse every 2 cycles.
    do_reset(12'h222, 3'b010);
    cyc_chk("single.c1", 3'b010, 1'b0, 2'd1);
    cyc_chk("single.c2", 3'b010, 1'b0, 2'd1);
    cyc_chk("single.c3", 3'b010, 1'b1, 2'd1);
    cyc_chk("single.c4", 3'b010, 1'b0, 2'd1);
    cyc_chk("single.c5", 3'b010, 1'b1, 2'd1);
    cyc_chk("single.c6", 3'b010, 1'b0, 2'd1);

    // Rotation with weights {3,1,2}.
    do_reset(12'h213, 3'b111);
    cyc_chk("rot.c1",  3'b100, 1'b0, 2'd0);
    cyc_chk("rot.c2",  3'b100, 1'b0, 2'd0);
    cyc_chk("rot.c3",  3'b100, 1'b0, 2'd0);
    cyc_chk("rot.c4",  3'b010, 1'b1, 2'd1);
    cyc_chk("rot.c5",  3'b001, 1'b1, 2'd2);
    cyc_chk("rot.c6",  3'b001, 1'b0, 2'd2);
    cyc_chk("rot.c7",  3'b100, 1'b1, 2'd0);
    cyc_chk("rot.c8",  3'b100, 1'b0, 2'd0);
    cyc_chk("rot.c9",  3'b100, 1'b0, 2'd0);
    cyc_chk("rot.c10", 3'b010, 1'b1, 2'd1);

    // Early release by port 0 after 2 cycles; port 1 then gets its full 5.
    do_reset(12'h555, 3'b110);
    cyc_chk("early.c1", 3'b100, 1'b0, 2'd0);
    cyc_chk("early.c2", 3'b100, 1'b0, 2'd0);
    bus.request = 3'b010;
    cyc_chk("early.c3", 3'b010, 1'b0, 2'd1);
    for (int i = 0; i < 4; i++) cyc_chk("early.hold", 3'b010, 1'b0, 2'd1);
    cyc_chk("early.regrant", 3'b010, 1'b1, 2'd1);

    // Idle and return: grant_id held through idle.
    do_reset(12'h333, 3'b001);
    cyc_chk("idle.c1", 3'b001, 1'b0, 2'd2);
    bus.request = 3'b000;
    cyc_chk("idle.c2", 3'b000, 1'b0, 2'd2);
    bus.request = 3'b100;
    cyc_chk("idle.c3", 3'b100, 1'b0, 2'd0);

    // Zero weight on port 1 behaves as a 1-cycle quota.
    do_reset(12'h505, 3'b010);
    cyc_chk("zero.c1", 3'b010, 1'b0, 2'd1);
    cyc_chk("zero.c2", 3'b010, 1'b1, 2'd1);
    cyc_chk("zero.c3", 3'b010, 1'b1, 2'd1);
    cyc_chk("zero.c4", 3'b010, 1'b1, 2'd1);

    // Asynchronous reset mid-grant, checked before the next rising edge.
    #2;
    rst = 1'b0;
    #1;
    chk("async.grant", 32'(bus.grant), 32'd0);
    chk("async.active", 32'(bus.active), 32'd0);
    chk("async.grant_id", 32'(bus.grant_id), 32'd0);
    chk("async.expired", 32'(bus.expired), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic, including weight changes and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 255) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) bus.request = 3'($urandom);
      if ($urandom_range(0, 31) == 0) bus.weight = 12'($urandom);
    end
    rst = 1'b1;
    @(negedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
